// File: rtl/cla_pkg.sv
// Shared constants and types for the pipelined carry-lookahead adder.
package cla_pkg;
  localparam int CLA_WIDTH = 16;
  localparam int CLA_GROUP = 4;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;
endpackage

// File: rtl/cla_gp_group.sv
// One lookahead slice: per-bit propagate/generate plus the slice's group G/P.
module cla_gp_group
  import cla_pkg::*;
#(
  parameter int GROUP = CLA_GROUP
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  output logic [GROUP-1:0] p,
  output logic [GROUP-1:0] g,
  output gp_t              gp
);

  assign p = a ^ b;
  assign g = a & b;

  // Folding from the LSB upward yields g[k-1] | p[k-1]&g[k-2] | ... | p[k-1]..p[1]&g[0].
  always_comb begin
    gp.g = 1'b0;
    for (int j = 0; j < GROUP; j++) begin
      gp.g = g[j] | (p[j] & gp.g);
    end
    gp.p = &p;
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshakes.
// Define CLA_OVF_EN to add the registered signed-overflow output ovf.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int GROUP = CLA_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NG = (GROUP >= 1) ? (WIDTH / GROUP) : 1;

  generate
    if (GROUP < 1) begin : g_bad_group
      $error("cla_pipe_adder: GROUP must be at least 1");
    end else if ((WIDTH % GROUP) != 0) begin : g_bad_width
      $error("cla_pipe_adder: WIDTH must be a multiple of GROUP");
    end
  endgenerate

  logic [WIDTH-1:0] b_eff;
  logic             c0_eff;
  logic [WIDTH-1:0] p_next;
  logic [WIDTH-1:0] g_next;
  gp_t  [NG-1:0]    gp_next;

  // Subtraction is a + ~b + 1, so cin is overridden rather than combined.
  assign b_eff  = sub ? ~b : b;
  assign c0_eff = sub | cin;

  genvar gi;
  generate
    for (gi = 0; gi < NG; gi++) begin : g_grp
      cla_gp_group #(
        .GROUP (GROUP)
      ) u_grp (
        .a  (a[gi*GROUP +: GROUP]),
        .b  (b_eff[gi*GROUP +: GROUP]),
        .p  (p_next[gi*GROUP +: GROUP]),
        .g  (g_next[gi*GROUP +: GROUP]),
        .gp (gp_next[gi])
      );
    end
  endgenerate

  logic             s1_valid_reg;
  logic [WIDTH-1:0] p_reg;
  logic [WIDTH-1:0] g_reg;
  gp_t  [NG-1:0]    gp_reg;
  logic             c0_reg;

  logic             s2_valid_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             s1_advance;

  assign s1_advance = !s2_valid_reg || out_ready;
  assign in_ready   = !s1_valid_reg || s1_advance;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      p_reg        <= '0;
      g_reg        <= '0;
      gp_reg       <= '0;
      c0_reg       <= 1'b0;
    end else if (in_ready) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        p_reg  <= p_next;
        g_reg  <= g_next;
        gp_reg <= gp_next;
        c0_reg <= c0_eff;
      end
    end
  end

  logic [NG:0]    gc;
  logic [WIDTH:0] carry;
  logic           lk_prod;

  // Each group carry is a flat sum of products over all lower groups, so no
  // group carry waits on another; only the bits inside a slice ripple.
  always_comb begin
    gc      = '0;
    lk_prod = 1'b0;
    gc[0]   = c0_reg;
    for (int k = 0; k < NG; k++) begin
      gc[k+1] = gp_reg[k].g;
      lk_prod = gp_reg[k].p;
      for (int m = k - 1; m >= 0; m--) begin
        gc[k+1] = gc[k+1] | (lk_prod & gp_reg[m].g);
        lk_prod = lk_prod & gp_reg[m].p;
      end
      gc[k+1] = gc[k+1] | (lk_prod & c0_reg);
    end

    carry = '0;
    for (int k = 0; k < NG; k++) begin
      carry[k*GROUP] = gc[k];
      for (int j = 1; j < GROUP; j++) begin
        carry[k*GROUP+j] = g_reg[k*GROUP+j-1] | (p_reg[k*GROUP+j-1] & carry[k*GROUP+j-1]);
      end
    end
    carry[WIDTH] = gc[NG];
  end

`ifdef CLA_OVF_EN
  logic ovf_reg;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      sum_reg      <= '0;
      cout_reg     <= 1'b0;
`ifdef CLA_OVF_EN
      ovf_reg      <= 1'b0;
`endif
    end else if (s1_advance) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        sum_reg  <= p_reg ^ carry[WIDTH-1:0];
        cout_reg <= carry[WIDTH];
`ifdef CLA_OVF_EN
        ovf_reg  <= carry[WIDTH-1] ^ carry[WIDTH];
`endif
      end
    end
  end

  assign out_valid = s2_valid_reg;
  assign sum       = sum_reg;
  assign cout      = cout_reg;
`ifdef CLA_OVF_EN
  assign ovf       = ovf_reg;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed checks of cla_pipe_adder (16/4) plus a random scoreboard run on a 32/8 instance.
// Define CLA_OVF_EN to include the overflow checks.
module tb_cla_pipe_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic        in_valid_16 = 1'b0, in_ready_16, cin_16 = 1'b0, sub_16 = 1'b0;
  logic        out_valid_16, out_ready_16 = 1'b1, cout_16;
  logic [15:0] a_16 = '0, b_16 = '0, sum_16;

  logic        in_valid_32 = 1'b0, in_ready_32, cin_32 = 1'b0, sub_32 = 1'b0;
  logic        out_valid_32, out_ready_32 = 1'b1, cout_32;
  logic [31:0] a_32 = '0, b_32 = '0, sum_32;

`ifdef CLA_OVF_EN
  logic ovf_16, ovf_32;
`endif

  cla_pipe_adder #(.WIDTH(16), .GROUP(4)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_16),
    .in_ready  (in_ready_16),
    .a         (a_16),
    .b         (b_16),
    .cin       (cin_16),
    .sub       (sub_16),
    .out_valid (out_valid_16),
    .out_ready (out_ready_16),
    .sum       (sum_16),
    .cout      (cout_16)
`ifdef CLA_OVF_EN
    ,
    .ovf       (ovf_16)
`endif
  );

  cla_pipe_adder #(.WIDTH(32), .GROUP(8)) dut32 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_32),
    .in_ready  (in_ready_32),
    .a         (a_32),
    .b         (b_32),
    .cin       (cin_32),
    .sub       (sub_32),
    .out_valid (out_valid_32),
    .out_ready (out_ready_32),
    .sum       (sum_32),
    .cout      (cout_32)
`ifdef CLA_OVF_EN
    ,
    .ovf       (ovf_32)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive16(input logic [15:0] av, input logic [15:0] bv, input logic c, input logic s);
    in_valid_16 = 1'b1;
    a_16        = av;
    b_16        = bv;
    cin_16      = c;
    sub_16      = s;
  endtask

  task automatic test_reset;
    #2;
    tests++;
    if (out_valid_16 !== 1'b0 || sum_16 !== 16'h0000 || cout_16 !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: got valid=%b sum=%h cout=%b, want 0 0000 0", out_valid_16, sum_16, cout_16);
    end
    tests++;
    if (out_valid_32 !== 1'b0 || sum_32 !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs32: got valid=%b sum=%h, want 0 00000000", out_valid_32, sum_32);
    end
`ifdef CLA_OVF_EN
    tests++;
    if (ovf_16 !== 1'b0) begin
      fails++;
      $display("FAIL reset_ovf: got %b, want 0", ovf_16);
    end
`endif
    tick;
    rst = 1'b0;
    tick;
    tests++;
    if (in_ready_16 !== 1'b1 || out_valid_16 !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1 0", in_ready_16, out_valid_16);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_add;
    drive16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    tick;
    in_valid_16 = 1'b0;
    tests++;
    if (out_valid_16 !== 1'b0) begin
      fails++;
      $display("FAIL add_latency_early: got out_valid=%b one cycle after transfer, want 0", out_valid_16);
    end
    tick;
    tests++;
    if (out_valid_16 !== 1'b1 || sum_16 !== 16'h0000 || cout_16 !== 1'b1) begin
      fails++;
      $display("FAIL add_wrap: got valid=%b sum=%h cout=%b, want 1 0000 1", out_valid_16, sum_16, cout_16);
    end
`ifdef CLA_OVF_EN
    tests++;
    if (ovf_16 !== 1'b0) begin
      fails++;
      $display("FAIL add_wrap_ovf: got %b, want 0", ovf_16);
    end
`endif
    tick;
    tests++;
    if (out_valid_16 !== 1'b0) begin
      fails++;
      $display("FAIL add_consumed: got out_valid=%b, want 0", out_valid_16);
    end
    drive16(16'h00FF, 16'h0F01, 1'b1, 1'b0);
    tick;
    in_valid_16 = 1'b0;
    tick;
    tests++;
    if (out_valid_16 !== 1'b1 || sum_16 !== 16'h1001 || cout_16 !== 1'b0) begin
      fails++;
      $display("FAIL add_cin: got valid=%b sum=%h cout=%b, want 1 1001 0", out_valid_16, sum_16, cout_16);
    end
    tick;
    $display("[TB] add: FFFF+0001 and 00FF+0F01+1 checked");
  endtask

  task automatic test_sub;
    drive16(16'h0005, 16'h0007, 1'b0, 1'b1);
    tick;
    drive16(16'h0007, 16'h0005, 1'b1, 1'b1);
    tests++;
    if (out_valid_16 !== 1'b0) begin
      fails++;
      $display("FAIL sub_latency_early: got out_valid=%b, want 0", out_valid_16);
    end
    tick;
    in_valid_16 = 1'b0;
    tests++;
    if (out_valid_16 !== 1'b1 || sum_16 !== 16'hFFFE || cout_16 !== 1'b0) begin
      fails++;
      $display("FAIL sub_5_minus_7: got valid=%b sum=%h cout=%b, want 1 FFFE 0", out_valid_16, sum_16, cout_16);
    end
    tick;
    tests++;
    if (out_valid_16 !== 1'b1 || sum_16 !== 16'h0002 || cout_16 !== 1'b1) begin
      fails++;
      $display("FAIL sub_7_minus_5: got valid=%b sum=%h cout=%b, want 1 0002 1", out_valid_16, sum_16, cout_16);
    end
    tick;
    tests++;
    if (out_valid_16 !== 1'b0) begin
      fails++;
      $display("FAIL sub_drained: got out_valid=%b, want 0", out_valid_16);
    end
    $display("[TB] sub: 5-7 and 7-5 (cin ignored) checked");
  endtask

  task automatic test_back_to_back;
    out_ready_16 = 1'b0;
    drive16(16'h1111, 16'h2222, 1'b0, 1'b0);
    tick;
    tests++;
    if (in_ready_16 !== 1'b1) begin
      fails++;
      $display("FAIL b2b_ready_one_full: got in_ready=%b, want 1", in_ready_16);
    end
    drive16(16'hF000, 16'h1000, 1'b0, 1'b0);
    tick;
    drive16(16'h0001, 16'h0001, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (in_ready_16 !== 1'b0 || out_valid_16 !== 1'b1 || sum_16 !== 16'h3333 || cout_16 !== 1'b0) begin
        fails++;
        $display("FAIL b2b_stall%0d: got in_ready=%b valid=%b sum=%h cout=%b, want 0 1 3333 0",
                 i, in_ready_16, out_valid_16, sum_16, cout_16);
      end
      tick;
    end
    out_ready_16 = 1'b1;
    tick;
    in_valid_16 = 1'b0;
    tests++;
    if (out_valid_16 !== 1'b1 || sum_16 !== 16'h0000 || cout_16 !== 1'b1) begin
      fails++;
      $display("FAIL b2b_second: got valid=%b sum=%h cout=%b, want 1 0000 1", out_valid_16, sum_16, cout_16);
    end
    tick;
    tests++;
    if (out_valid_16 !== 1'b1 || sum_16 !== 16'h0002 || cout_16 !== 1'b0) begin
      fails++;
      $display("FAIL b2b_third: got valid=%b sum=%h cout=%b, want 1 0002 0", out_valid_16, sum_16, cout_16);
    end
    tick;
    tests++;
    if (out_valid_16 !== 1'b0) begin
      fails++;
      $display("FAIL b2b_drained: got out_valid=%b, want 0", out_valid_16);
    end
    $display("[TB] back-to-back with stalled consumer checked");
  endtask

  task automatic test_reset_midflight;
    drive16(16'h0101, 16'h0202, 1'b0, 1'b0);
    tick;
    drive16(16'h0303, 16'h0404, 1'b0, 1'b0);
    tick;
    in_valid_16 = 1'b0;
    tests++;
    if (out_valid_16 !== 1'b1 || sum_16 !== 16'h0303) begin
      fails++;
      $display("FAIL midrst_before: got valid=%b sum=%h, want 1 0303", out_valid_16, sum_16);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (out_valid_16 !== 1'b0 || sum_16 !== 16'h0000 || cout_16 !== 1'b0) begin
      fails++;
      $display("FAIL midrst_async: got valid=%b sum=%h cout=%b, want 0 0000 0", out_valid_16, sum_16, cout_16);
    end
    tick;
    tick;
    rst = 1'b0;
    tick;
    tests++;
    if (out_valid_16 !== 1'b0 || in_ready_16 !== 1'b1) begin
      fails++;
      $display("FAIL midrst_release: got valid=%b in_ready=%b, want 0 1", out_valid_16, in_ready_16);
    end
    tick;
    tests++;
    if (out_valid_16 !== 1'b0) begin
      fails++;
      $display("FAIL midrst_stale: got out_valid=%b sum=%h, want no result", out_valid_16, sum_16);
    end
    drive16(16'h0100, 16'h0200, 1'b0, 1'b0);
    tick;
    in_valid_16 = 1'b0;
    tick;
    tests++;
    if (out_valid_16 !== 1'b1 || sum_16 !== 16'h0300 || cout_16 !== 1'b0) begin
      fails++;
      $display("FAIL midrst_next: got valid=%b sum=%h cout=%b, want 1 0300 0", out_valid_16, sum_16, cout_16);
    end
    tick;
    $display("[TB] reset with two in flight checked");
  endtask

`ifdef CLA_OVF_EN
  task automatic test_ovf;
    drive16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    tick;
    drive16(16'h8000, 16'h8000, 1'b0, 1'b0);
    tick;
    in_valid_16 = 1'b0;
    tests++;
    if (sum_16 !== 16'h8000 || cout_16 !== 1'b0 || ovf_16 !== 1'b1) begin
      fails++;
      $display("FAIL ovf_pos: got sum=%h cout=%b ovf=%b, want 8000 0 1", sum_16, cout_16, ovf_16);
    end
    tick;
    tests++;
    if (sum_16 !== 16'h0000 || cout_16 !== 1'b1 || ovf_16 !== 1'b1) begin
      fails++;
      $display("FAIL ovf_neg: got sum=%h cout=%b ovf=%b, want 0000 1 1", sum_16, cout_16, ovf_16);
    end
    tick;
    $display("[TB] overflow checked");
  endtask
`endif

  task automatic test_random;
    logic [32:0] q[$];
    logic [32:0] exp_v;
    logic [32:0] obs;
    logic        acc;
    logic        dlv;
    int          sent = 0;
    int          got  = 0;
    int          cyc  = 0;
    a_32   = $urandom;
    b_32   = $urandom;
    cin_32 = 1'($urandom_range(0, 1));
    sub_32 = 1'($urandom_range(0, 1));
    while ((sent < 1000 || got < sent) && cyc < 20000) begin
      in_valid_32  = (sent < 1000);
      out_ready_32 = ($urandom_range(0, 3) != 0);
      #1;
      acc = in_valid_32 && in_ready_32;
      dlv = out_valid_32 && out_ready_32;
      obs = {cout_32, sum_32};
      tick;
      if (acc) begin
        if (sub_32)
          q.push_back({1'b0, a_32} + {1'b0, ~b_32} + 33'd1);
        else
          q.push_back({1'b0, a_32} + {1'b0, b_32} + {32'd0, cin_32});
        sent++;
        a_32   = $urandom;
        b_32   = $urandom;
        cin_32 = 1'($urandom_range(0, 1));
        sub_32 = 1'($urandom_range(0, 1));
      end
      if (dlv) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL random_extra: got unexpected result %h, want none", obs);
        end else begin
          exp_v = q.pop_front();
          if (obs !== exp_v) begin
            fails++;
            $display("FAIL random_%0d: got {cout,sum}=%h, want %h", got, obs, exp_v);
          end
        end
        got++;
      end
      cyc++;
    end
    in_valid_32  = 1'b0;
    out_ready_32 = 1'b1;
    tests++;
    if (got != 1000 || q.size() != 0) begin
      fails++;
      $display("FAIL random_count: got %0d results (%0d pending), want 1000 (0 pending)", got, q.size());
    end
    $display("[TB] random: %0d sent, %0d delivered in %0d cycles", sent, got, cyc);
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_back_to_back;
    test_reset_midflight;
`ifdef CLA_OVF_EN
    test_ovf;
`endif
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
